// File: rtl/btn_debouncer_pkg.sv
// rtl/btn_debouncer_pkg.sv - shared FSM encoding and default timing constants for the button debouncer
package btn_debouncer_pkg;

    localparam int DEFAULT_NUM_BTN         = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_REPEAT_CYCLES   = 2500000;

    localparam logic [2:0] ST_INI  = 3'd0;
    localparam logic [2:0] ST_WQ   = 3'd1;
    localparam logic [2:0] ST_SCEN = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_WQR  = 3'd4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debouncer_if.sv
// rtl/btn_debouncer_if.sv - raw button inputs and debounced outputs bundled as one port group
interface btn_debouncer_if
    import btn_debouncer_pkg::*;
#(
    parameter int NUM_BTN = DEFAULT_NUM_BTN
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] db_level;
    logic [NUM_BTN-1:0] scen;
    logic [NUM_BTN-1:0] mcen;

    modport master (output btn_raw, input db_level, input scen, input mcen);
    modport slave  (input btn_raw, output db_level, output scen, output mcen);
endinterface

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one debounce channel: 2-flop synchronizer, qualification FSM, optional auto-repeat
module btn_debounce_ch
    import btn_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db_level,
    output logic scen,
    output logic mcen
);
    localparam int CW = $clog2(max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES));
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    // Any sample disagreeing with the candidate level drops out of WQ/WQR, so qualification restarts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INI;
            cnt   <= '0;
        end else begin
            case (state)
                ST_INI: begin
                    cnt <= '0;
                    if (s) state <= ST_WQ;
                end
                ST_WQ: begin
                    if (!s) begin
                        state <= ST_INI;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= ST_SCEN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_SCEN: begin
                    state <= ST_HOLD;
                    cnt   <= '0;
                end
                ST_HOLD: begin
                    if (!s) begin
                        state <= ST_WQR;
                        cnt   <= '0;
                    end
                end
                ST_WQR: begin
                    if (s) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= ST_INI;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= ST_INI;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_level <= 1'b0;
            scen     <= 1'b0;
        end else begin
            db_level <= (state == ST_SCEN) || (state == ST_HOLD) || (state == ST_WQR);
            scen     <= (state == ST_SCEN);
        end
    end

`ifdef BTN_DEBOUNCER_MCEN_EN
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES - 1);

    logic [CW-1:0] rcnt;

    // Held at zero outside HOLD, so both SCEN->HOLD and WQR->HOLD start a fresh repeat period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt <= '0;
            mcen <= 1'b0;
        end else begin
            mcen <= (state == ST_SCEN) || ((state == ST_HOLD) && (rcnt == RP_LAST));
            if (state != ST_HOLD || rcnt == RP_LAST) rcnt <= '0;
            else                                     rcnt <= rcnt + 1'b1;
        end
    end
`else
    assign mcen = 1'b0;
`endif

endmodule

// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - NUM_BTN independent button debouncers; auto-repeat on mcen via BTN_DEBOUNCER_MCEN_EN
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int NUM_BTN         = DEFAULT_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input logic            clk,
    input logic            reset,
    btn_debouncer_if.slave bus
);
    logic [NUM_BTN-1:0] db_level_v;
    logic [NUM_BTN-1:0] scen_v;
    logic [NUM_BTN-1:0] mcen_v;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .raw     (bus.btn_raw[i]),
            .db_level(db_level_v[i]),
            .scen    (scen_v[i]),
            .mcen    (mcen_v[i])
        );
    end

    assign bus.db_level = db_level_v;
    assign bus.scen     = scen_v;
    assign bus.mcen     = mcen_v;

endmodule

// File: tb/tb_btn_debouncer.sv
// tb/tb_btn_debouncer.sv - directed and random checks of btn_debouncer against a run-length reference model
module tb_btn_debouncer;
    localparam int NB = 4;
    localparam int D  = 8;
    localparam int R  = 16;
`ifdef BTN_DEBOUNCER_MCEN_EN
    localparam bit MCEN_ON = 1'b1;
`else
    localparam bit MCEN_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    btn_debouncer_if #(.NUM_BTN(NB)) bus ();

    btn_debouncer #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    int edge_n;
    logic [NB-1:0] h1, h2, exp_db, exp_sc, exp_mc, prev_db;
    bit m_lvl[NB];
    int m_run[NB], m_rise[NB], m_hold[NB];
    int sc_cnt[NB], sc_edge[NB], mc_cnt[NB], mc_last[NB], fall_cnt[NB], fall_edge[NB];
    int rem[NB];
    logic [NB-1:0] rlvl;

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        edge_n = 0; h1 = '0; h2 = '0; prev_db = '0;
        exp_db = '0; exp_sc = '0; exp_mc = '0;
        for (int c = 0; c < NB; c++) begin
            m_lvl[c] = 1'b0; m_run[c] = 0; m_rise[c] = -100; m_hold[c] = 0;
            sc_cnt[c] = 0; sc_edge[c] = -1; mc_cnt[c] = 0; mc_last[c] = -1;
            fall_cnt[c] = 0; fall_edge[c] = -1;
        end
    endtask

    // Level flips once D+1 consecutive synchronized samples oppose it; the sample in the
    // pulse cycle right after a press is not looked at. Repeats every R cycles of unbroken hold.
    task automatic model_edge(input logic [NB-1:0] raw);
        logic [NB-1:0] s;
        bit held;
        s = h2; h2 = h1; h1 = raw;
        for (int c = 0; c < NB; c++) begin
            exp_db[c] = m_lvl[c];
            exp_sc[c] = (m_rise[c] == edge_n - 1);
            held = m_lvl[c] && (m_rise[c] != edge_n - 1) && (m_run[c] == 0);
            exp_mc[c] = MCEN_ON && (exp_sc[c] || (held && ((edge_n - 1 - m_hold[c]) % R == R - 1)));
            if ((s[c] != m_lvl[c]) && !(m_lvl[c] && edge_n == m_rise[c] + 1)) begin
                m_run[c]++;
            end else begin
                if (m_lvl[c] && m_run[c] > 0) m_hold[c] = edge_n;
                m_run[c] = 0;
            end
            if (m_run[c] == D + 1) begin
                m_lvl[c] = !m_lvl[c];
                m_run[c] = 0;
                if (m_lvl[c]) begin
                    m_rise[c] = edge_n;
                    m_hold[c] = edge_n + 1;
                end
            end
        end
    endtask

    task automatic step(input logic [NB-1:0] raw);
        bus.btn_raw = raw;
        @(posedge clk);
        model_edge(raw);
        @(negedge clk);
        check("db_level", bus.db_level, exp_db);
        check("scen", bus.scen, exp_sc);
        check("mcen", bus.mcen, exp_mc);
        for (int c = 0; c < NB; c++) begin
            if (bus.scen[c]) begin sc_cnt[c]++; sc_edge[c] = edge_n; end
            if (bus.mcen[c]) begin mc_cnt[c]++; mc_last[c] = edge_n; end
            if (prev_db[c] && !bus.db_level[c]) begin fall_cnt[c]++; fall_edge[c] = edge_n; end
        end
        prev_db = bus.db_level;
        edge_n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_db_level", bus.db_level, '0);
        check("reset_scen", bus.scen, '0);
        check("reset_mcen", bus.mcen, '0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        bus.btn_raw = 4'hF;
        model_reset();
        repeat (2) @(negedge clk);
        check("init_db_level", bus.db_level, '0);
        check("init_scen", bus.scen, '0);
        check("init_mcen", bus.mcen, '0);
        reset = 1'b0;

        // 1: all four pressed together
        for (int k = 0; k < 20; k++) step(4'hF);
        for (int c = 0; c < NB; c++) begin
            check_int($sformatf("t1_scen_cnt%0d", c), sc_cnt[c], 1);
            check_int($sformatf("t1_scen_edge%0d", c), sc_edge[c], 11);
        end
        for (int k = 0; k < 20; k++) step(4'h0);

        // 2: clean press and release on channel 0
        do_reset();
        for (int k = 0; k < 40; k++) step(4'h1);
        for (int k = 0; k < 20; k++) step(4'h0);
        check_int("t2_scen_cnt", sc_cnt[0], 1);
        check_int("t2_scen_edge", sc_edge[0], 11);
        check_int("t2_fall_edge", fall_edge[0], 51);

        // 3: fast chatter on channel 1 never qualifies
        do_reset();
        for (int k = 0; k < 24; k++) step(((k / 3) % 2 == 0) ? 4'h2 : 4'h0);
        for (int k = 0; k < 20; k++) step(4'h0);
        check_int("t3_scen_cnt", sc_cnt[1], 0);
        check_int("t3_fall_cnt", fall_cnt[1], 0);

        // 4: short low glitch while channel 2 is held
        do_reset();
        for (int k = 0; k < 60; k++) step((k >= 25 && k < 29) ? 4'h0 : 4'h4);
        check_int("t4_fall_during_hold", fall_cnt[2], 0);
        for (int k = 0; k < 20; k++) step(4'h0);
        check_int("t4_scen_cnt", sc_cnt[2], 1);
        check_int("t4_fall_cnt", fall_cnt[2], 1);

        // 5: reset in the middle of a channel 3 hold
        do_reset();
        for (int k = 0; k < 20; k++) step(4'h8);
        do_reset();
        for (int k = 0; k < 20; k++) step(4'h8);
        check_int("t5_scen_cnt", sc_cnt[3], 1);
        check_int("t5_scen_edge", sc_edge[3], 11);
        for (int k = 0; k < 20; k++) step(4'h0);

        // 6: long hold for auto-repeat
        do_reset();
        for (int k = 0; k < 60; k++) step(4'h1);
        check_int("t6_mcen_cnt", mc_cnt[0], MCEN_ON ? 4 : 0);
        check_int("t6_mcen_last", mc_last[0], MCEN_ON ? 59 : -1);
        for (int k = 0; k < 20; k++) step(4'h0);

        // random bounce patterns on all channels, with one mid-run reset
        do_reset();
        rlvl = '0;
        for (int c = 0; c < NB; c++) rem[c] = $urandom_range(1, 22);
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset();
            for (int c = 0; c < NB; c++) begin
                if (rem[c] == 0) begin
                    rlvl[c] = ~rlvl[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 60) : $urandom_range(1, 22);
                end
                rem[c]--;
            end
            step(rlvl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
